// File: rtl/axi_tdd_pkg.sv
// Shared types and limits for the TDD channel array.
package axi_tdd_pkg;

    localparam int MAX_CHANNELS = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        WAITING = 2'd2,
        RUNNING = 2'd3
    } state_t;

endpackage

// File: rtl/axi_tdd_channel.sv
// One TDD output channel: on/off compare, active flag and registered output.
module axi_tdd_channel #(
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      running_i,
    input  logic [REGISTER_WIDTH-1:0] counter_i,
    input  logic                      en_i,
    input  logic                      pol_i,
    input  logic [REGISTER_WIDTH-1:0] on_i,
    input  logic [REGISTER_WIDTH-1:0] off_i,
    output logic                      channel_o
);

    logic set, clr;
    logic active_q, active_d;
    logic pulse_q, pulse_d;
    logic out_q, out_d;

    assign set = running_i && (counter_i == on_i);
    assign clr = running_i && (counter_i == off_i);

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        active_d = active_q;
        pulse_d  = set && clr;
        out_d    = en_i && (active_q ^ pol_i);
        if (!running_i) begin
            active_d = 1'b0;
        end else if (set) begin
            active_d = 1'b1;
        end else if (clr || pulse_q) begin
            // pulse_q ends the one-clock window opened when on == off
            active_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            active_q <= 1'b0;
            pulse_q  <= 1'b0;
            out_q    <= 1'b0;
        end else begin
            active_q <= active_d;
            pulse_q  <= pulse_d;
            out_q    <= out_d;
        end
    end

    assign channel_o = out_q;

endmodule

// File: rtl/axi_tdd_channel_array.sv
// Array of independent TDD output channels driven from a shared frame counter.
// Channel configuration is sampled only while tdd_enable is high.
module axi_tdd_channel_array
    import axi_tdd_pkg::*;
#(
    parameter int NUM_CHANNELS   = 8,
    parameter int REGISTER_WIDTH = 32
) (
    input  logic                                   clk,
    input  logic                                   resetn,
    input  logic                                   tdd_enable,
    input  logic [REGISTER_WIDTH-1:0]              tdd_counter,
    input  state_t                                 tdd_cstate,
    input  logic [NUM_CHANNELS-1:0]                asy_tdd_channel_en,
    input  logic [NUM_CHANNELS-1:0]                asy_tdd_channel_pol,
    input  logic [NUM_CHANNELS*REGISTER_WIDTH-1:0] asy_tdd_channel_on,
    input  logic [NUM_CHANNELS*REGISTER_WIDTH-1:0] asy_tdd_channel_off,
    output logic [NUM_CHANNELS-1:0]                tdd_channel
);

    if (NUM_CHANNELS < 1 || NUM_CHANNELS > MAX_CHANNELS) begin : g_bad_num_channels
        $error("NUM_CHANNELS must be in 1..MAX_CHANNELS");
    end

    logic [NUM_CHANNELS-1:0]   en_q;
    logic [NUM_CHANNELS-1:0]   pol_q;
    logic [REGISTER_WIDTH-1:0] on_q  [NUM_CHANNELS];
    logic [REGISTER_WIDTH-1:0] off_q [NUM_CHANNELS];
    logic                      running;

    assign running = (tdd_cstate == RUNNING);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            en_q  <= '0;
            pol_q <= '0;
            // NOTE: these arrays are flops, not a RAM, so they can and must be cleared in reset.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                on_q[i]  <= '0;
                off_q[i] <= '0;
            end
        end else if (tdd_enable) begin
            en_q  <= asy_tdd_channel_en;
            pol_q <= asy_tdd_channel_pol;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                on_q[i]  <= asy_tdd_channel_on[i*REGISTER_WIDTH +: REGISTER_WIDTH];
                off_q[i] <= asy_tdd_channel_off[i*REGISTER_WIDTH +: REGISTER_WIDTH];
            end
        end
    end

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_channel
        axi_tdd_channel #(
            .REGISTER_WIDTH(REGISTER_WIDTH)
        ) u_channel (
            .clk      (clk),
            .resetn   (resetn),
            .running_i(running),
            .counter_i(tdd_counter),
            .en_i     (en_q[g]),
            .pol_i    (pol_q[g]),
            .on_i     (on_q[g]),
            .off_i    (off_q[g]),
            .channel_o(tdd_channel[g])
        );
    end

endmodule

// File: doc/axi_tdd_channel_array.md
AXI_TDD_CHANNEL_ARRAY -- requirements
Module: axi_tdd_channel_array

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 8, number of TDD output channels (1..32).
REQ-002 SHALL have parameter REGISTER_WIDTH, default 32, width of the frame counter and the on/off compare values.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; every flop is in this domain.
REQ-004 SHALL have port resetn, input, 1 bit, reset; synchronous and active-low.
REQ-005 SHALL have port tdd_enable, input, 1 bit, global enable; gates capture of asy_* configuration.
REQ-006 SHALL have port tdd_counter, input, REGISTER_WIDTH, frame position from the upstream counter.
REQ-007 SHALL have port tdd_cstate, input, axi_tdd_pkg::state_t, upstream FSM state (IDLE/ARMED/WAITING/RUNNING).
REQ-008 SHALL have port asy_tdd_channel_en, input, NUM_CHANNELS, per-channel enable, quasi-static.
REQ-009 SHALL have port asy_tdd_channel_pol, input, NUM_CHANNELS, per-channel polarity (1 = active-low output).
REQ-010 SHALL have port asy_tdd_channel_on, input, NUM_CHANNELS x REGISTER_WIDTH, per-channel assert position.
REQ-011 SHALL have port asy_tdd_channel_off, input, NUM_CHANNELS x REGISTER_WIDTH, per-channel deassert position.
REQ-012 SHALL have port tdd_channel, output, NUM_CHANNELS, registered per-channel TDD control outputs.

Function
REQ-013 SHALL capture all asy_* inputs into local registers on every clk edge while tdd_enable=1; hold them while tdd_enable=0.
REQ-014 SHALL define, per channel, set = (tdd_cstate==RUNNING) && (tdd_counter==on_reg) and clr = (tdd_cstate==RUNNING) && (tdd_counter==off_reg).
REQ-015 SHALL keep, per channel, an internal active flag: set only -> 1; clr only -> 0; neither -> hold.
REQ-016 SHALL, when set and clr coincide (on==off), assert active for exactly one clock, then return to 0.
REQ-017 SHALL force every active flag to 0 on the first edge where tdd_cstate != RUNNING.
REQ-018 SHALL support off<on (wrap): active stays 1 across the frame boundary until the counter reaches off in the next frame.
REQ-019 SHALL never assert a channel whose on_reg is never reached by the counter (e.g. on >= frame length).
REQ-020 SHALL drive tdd_channel[i] = en_reg[i] ? (active[i] XOR pol_reg[i]) : 0, registered.
REQ-021 SHALL give total latency of 2 clocks from the counter==on/off cycle to the tdd_channel edge (one for active, one for the output register).
REQ-022 SHALL treat a counter jump to 0 mid-frame (sync reset) as ordinary counter values, with no extra clearing of active.
REQ-023 SHALL make each channel independent; no ordering or priority between channels.

Reset
REQ-024 SHALL, while resetn=0 at a clk edge, clear all captured config, all active flags and tdd_channel to 0.
REQ-025 SHALL, after reset release, resume capture only while tdd_enable=1, with all outputs 0 until a RUNNING match.

Structure
REQ-026 SHALL take state_t from axi_tdd_pkg; place a MAX_CHANNELS=32 constant in the same package.
REQ-027 SHALL instantiate NUM_CHANNELS copies of a sub-module axi_tdd_channel containing compare, active flag and output register.

Verification
REQ-028 SHALL test frame=100, on=10, off=20, pol=0: tdd_channel high from cycle counter=10 +2 to counter=20 +2, i.e. 10 clocks per frame.
REQ-029 SHALL test on=90, off=5, frame=100: output high across the frame wrap, 15 clocks per frame.
REQ-030 SHALL test on=off=30: exactly one-clock pulse per frame; with pol=1, a one-clock low pulse on an idle-high line.
REQ-031 SHALL test RUNNING->ARMED mid-window (counter=15, on=10, off=20): output returns to the inactive level 2 clocks later.
REQ-032 SHALL test en=0 with pol=1: output constantly 0; with resetn=0 mid-window, output 0 on the next edge.
